alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Command front-end and result register for the 8-bit ALU (alu_8bit).
//  - Buffers {A,B,op} commands in a FIFO with a valid/ready handshake.
//  - Drives the FIFO head combinationally into alu_8bit.
//  - Captures {carry,result} plus derived flags into an output register with its own valid/ready handshake.
//  - Sits between the instruction/control path and the consumers of ALU results.
// PARAMETERS
//  DEPTH  4  Command FIFO entries; power of two, >= 2.
//  CW     $clog2(DEPTH)+1  Width of fifo_count; localparam, not overridable.
// PORTS
//  clk          in   1   Single clock; all state updates on rising edge.
//  rst          in   1   Synchronous, active-high reset.
//  cmd_valid    in   1   Command present on cmd_a/cmd_b/cmd_op.
//  cmd_ready    out  1   FIFO can accept; equals (fifo_count < DEPTH).
//  cmd_a        in   8   Operand A.
//  cmd_b        in   8   Operand B.
//  cmd_op       in   3   ALU opcode; 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
//  alu_a        out  8   To alu_8bit.A. FIFO head A; 0 when the FIFO is empty.
//  alu_b        out  8   To alu_8bit.B. FIFO head B; 0 when the FIFO is empty.
//  alu_op       out  3   To alu_8bit.op. FIFO head op; 0 when the FIFO is empty.
//  alu_result   in   8   From alu_8bit.result.
//  alu_carry    in   1   From alu_8bit.carry.
//  res_valid    out  1   Output register holds an unconsumed result.
//  res_ready    in   1   Consumer accepts the result.
//  res_data     out  8   Captured result.
//  res_carry    out  1   Captured carry (for SUB, this is the borrow bit).
//  res_zero     out  1   High when captured res_data == 0.
//  res_illegal  out  1   High when the captured op was 101..111.
//  fifo_count   out  CW  Number of occupied FIFO entries, 0..DEPTH.
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all of the following are cleared in one cycle, including mid-transfer:
//    - fifo_count=0; read and write pointers=0.
//    - res_valid=0, res_data=0, res_carry=0, res_zero=0, res_illegal=0.
//    - Any buffered commands are discarded.
//  - Push: cmd_valid & cmd_ready. Entry is written at the write pointer, which then increments and wraps mod DEPTH.
//  - cmd_ready depends on fifo_count only, never on the same-cycle pop. When full, cmd_ready=0 even if a pop occurs that cycle.
//  - Capture condition: cap = (fifo_count!=0) & (~res_valid | res_ready). On cap:
//    - res_data<=alu_result, res_carry<=alu_carry, res_zero<=(alu_result==0).
//    - res_illegal<=(alu_op>3'b100).
//    - res_valid<=1; the head is popped and the read pointer wraps mod DEPTH.
//  - Drain without capture: res_valid & res_ready & ~cap drives res_valid<=0. The res_* data fields hold their values.
//  - Simultaneous push and pop: fifo_count is unchanged; both pointers advance.
//  - Latency: a command accepted at edge N into an empty FIFO with a free output register gives res_valid=1 after edge N+1.
//  - Throughput: 1 result/cycle while res_ready stays high.
//  - Stall: res_valid=1 & res_ready=0 means the FIFO fills. cmd_ready falls when fifo_count reaches DEPTH. res_* stays stable.
//  - Illegal ops are passed through to alu_8bit, which returns 0 with carry 0. They are captured with res_illegal=1 and res_zero=1.
//  - Width rule: no arithmetic is done here. Carry and result are taken verbatim from alu_8bit.
// CONFIGURATION
//  ALU_ISSUE_ACC_EN (define to enable accumulator chaining):
//  - Adds input port cmd_use_acc (1 bit), stored per FIFO entry.
//  - Adds an 8-bit acc register, reset 0, loaded with alu_result on every cap.
//  - When the head's cmd_use_acc=1, alu_a=acc instead of the stored A. acc always holds the most recently captured result.
//  - Undefined: no port and no acc register; alu_a is always the stored A.
// TESTING
//  - Reset then push {A=8'hF0, B=8'h20, op=000} with res_ready=1. One cycle later: res_valid=1, res_data=8'h10, res_carry=1, res_zero=0.
//  - Push {8'h05, 8'h05, 001}. Expect res_data=8'h00, res_carry=0, res_zero=1. Push {8'h03, 8'h05, 001}: expect 8'hFE, carry=1.
//  - Hold res_ready=0 and push 6 commands.
//    - Expect 4 in the FIFO plus 1 captured; cmd_ready falls when fifo_count reaches 4.
//    - Release res_ready: results arrive in order, one per cycle.
//  - Push op=3'b110 with A=8'hAA. Expect res_data=0, res_illegal=1, res_zero=1, res_carry=0.
//  - Assert rst while fifo_count=3 and res_valid=1. Next cycle: fifo_count=0, res_valid=0, cmd_ready=1.
//  - ALU_ISSUE_ACC_EN: push {1,2,000} then {x,4,000,use_acc=1}. Expect results 3 then 7.

Source files
------------

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - command FIFO and result register in front of alu_8bit
//
// Buffers {A,B,op} commands in a DEPTH-entry FIFO, presents the FIFO head
// combinationally to alu_8bit, and captures {carry,result} plus zero and
// illegal-op flags into a result register with its own valid/ready handshake.
//
// Optional feature macro: ALU_ISSUE_ACC_EN (accumulator chaining).
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (cmd_a, cmd_b, cmd_op)
//   cmd_use_acc                  (ALU_ISSUE_ACC_EN only) use acc in place of A
//   alu_a/alu_b/alu_op           FIFO head to alu_8bit, zero when empty
//   alu_result/alu_carry         alu_8bit outputs
//   res_valid/res_ready          result handshake
//   res_data/res_carry           captured result and carry/borrow
//   res_zero/res_illegal         captured flags
//   fifo_count                   occupied FIFO entries, 0..DEPTH

module alu_issue_stage #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_a,
    input  logic [7:0]    cmd_b,
    input  logic [2:0]    cmd_op,
`ifdef ALU_ISSUE_ACC_EN
    input  logic          cmd_use_acc,
`endif
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [2:0]    alu_op,
    input  logic [7:0]    alu_result,
    input  logic          alu_carry,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [7:0]    res_data,
    output logic          res_carry,
    output logic          res_zero,
    output logic          res_illegal,
    output logic [CW-1:0] fifo_count
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem_a  [DEPTH];
    logic [7:0]    mem_b  [DEPTH];
    logic [2:0]    mem_op [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          fifo_empty;
    logic          push;
    logic          cap;

    assign fifo_empty = (fifo_count == '0);

    // Ready looks only at occupancy so that it never depends on res_ready
    // through a same-cycle pop.
    assign cmd_ready  = (fifo_count < CW'(DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign cap        = ~fifo_empty & (~res_valid | res_ready);

`ifdef ALU_ISSUE_ACC_EN
    logic          mem_use_acc [DEPTH];
    logic [7:0]    acc;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_use_acc[wr_ptr] <= cmd_use_acc;
        end
    end

    // acc tracks the most recently captured result so a chained command
    // sees its predecessor's result even when issued back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (cap) begin
            acc <= alu_result;
        end
    end
`endif

    // Storage is not reset: entries are only ever read below the count,
    // which reset clears.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
            mem_op[wr_ptr] <= cmd_op;
        end
    end

    // Head presentation; forced to zero when empty so the ALU sees a
    // deterministic ADD 0,0 rather than stale storage.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (!fifo_empty) begin
`ifdef ALU_ISSUE_ACC_EN
            alu_a  = mem_use_acc[rd_ptr] ? acc : mem_a[rd_ptr];
`else
            alu_a  = mem_a[rd_ptr];
`endif
            alu_b  = mem_b[rd_ptr];
            alu_op = mem_op[rd_ptr];
        end
    end

    // Pointers and occupancy. DEPTH is a power of two, so the natural
    // PW-bit rollover is the mod-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (cap) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, cap})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Result register. A drain without a new capture only drops valid;
    // the data fields keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_carry   <= 1'b0;
            res_zero    <= 1'b0;
            res_illegal <= 1'b0;
        end else if (cap) begin
            res_valid   <= 1'b1;
            res_data    <= alu_result;
            res_carry   <= alu_carry;
            res_zero    <= (alu_result == 8'h00);
            res_illegal <= (alu_op > 3'b100);
        end else if (res_valid && res_ready) begin
            res_valid   <= 1'b0;
        end
    end

endmodule
